// File: rtl/nand_cell_arbiter_if.sv
// Requester-side bus of the NAND cell arbiter: request/operands in, grant and response out.
interface nand_cell_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  // Handshake: a requester holds req[i] (with stable req_a[i]/req_b[i]) until it sees
  // gnt[i] for one cycle, then drops req[i]; its result arrives later as a one-cycle
  // rsp_valid pulse tagged with rsp_id == i. gnt and rsp_valid are never high together.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_a;
  logic [N_REQ-1:0] req_b;
  logic [N_REQ-1:0] gnt;
  logic             rsp_valid;
  logic [ID_W-1:0]  rsp_id;
  logic             rsp_f;
  logic             busy;

  modport master (
    output req, req_a, req_b,
    input  gnt, rsp_valid, rsp_id, rsp_f, busy
  );

  modport slave (
    input  req, req_a, req_b,
    output gnt, rsp_valid, rsp_id, rsp_f, busy
  );
endinterface

// File: rtl/nand_cell_arbiter.sv
// Round-robin scheduler for one shared two-input NAND cell: grant, drive, settle, sample.
// Optional macro NAND_CELL_CHECK_EN adds a sticky result checker (chk_err, err_cnt).
module nand_cell_arbiter #(
  parameter int N_REQ      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nand_cell_arbiter_if.slave    bus,
  output logic                  gate_a,
  output logic                  gate_b,
  input  logic                  gate_f,
  output logic [1:0]            dbg_state_o
`ifdef NAND_CELL_CHECK_EN
  ,
  output logic                  chk_err,
  output logic [7:0]            err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  // A zero settle interval still needs one edge between driving and sampling the cell.
  localparam int SETTLE_EFF = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_EFF - 1);

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_f_q, rsp_f_d;
  logic               gate_a_q, gate_a_d;
  logic               gate_b_q, gate_b_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               capture;
  logic               any_req;
  logic [ID_W-1:0]    win_idx;

  // First set request at or after rr_ptr, searching upward with wrap.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_req && bus.req[(int'(rr_ptr_q) + k) % N_REQ]) begin
        any_req = 1'b1;
        win_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_f_d     = rsp_f_q;
    gate_a_d    = gate_a_q;
    gate_b_d    = gate_b_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d    = N_REQ'(1) << win_idx;
          gate_a_d = bus.req_a[win_idx];
          gate_b_d = bus.req_b[win_idx];
          id_d     = win_idx;
          cnt_d    = CNT_INIT;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          capture     = 1'b1;
          rsp_f_d     = gate_f;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_f_q     <= 1'b0;
      gate_a_q    <= 1'b0;
      gate_b_q    <= 1'b0;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_f_q     <= rsp_f_d;
      gate_a_q    <= gate_a_d;
      gate_b_q    <= gate_b_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef NAND_CELL_CHECK_EN
  logic       chk_err_q;
  logic [7:0] err_cnt_q;
  logic       mismatch;

  // Case inequality so an X/Z cell output counts as a wrong answer.
  assign mismatch = (gate_f !== ~(gate_a_q & gate_b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else if (capture && mismatch) begin
      chk_err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign chk_err = chk_err_q;
  assign err_cnt = err_cnt_q;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.busy      = (state_q != IDLE);
  assign gate_a        = gate_a_q;
  assign gate_b        = gate_b_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_nand_cell_arbiter.sv
// Bench for nand_cell_arbiter: vector table, corner sequences and a randomized run
// against a transaction-level round-robin model; a second instance covers SETTLE_CYC=0.
module tb_nand_cell_arbiter;

  localparam int N  = 4;
  localparam int SC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;

  nand_cell_arbiter_if #(.N_REQ(N), .ID_W(2)) bus ();
  nand_cell_arbiter_if #(.N_REQ(N), .ID_W(2)) bus0 ();

  logic       gate_a, gate_b, gate_f, stuck;
  logic       gate_a0, gate_b0, gate_f0;
  logic [1:0] dbg_state, dbg_state0;

  // Ideal NAND cell, optionally stuck at 1.
  assign gate_f  = stuck ? 1'b1 : ~(gate_a & gate_b);
  assign gate_f0 = ~(gate_a0 & gate_b0);

`ifdef NAND_CELL_CHECK_EN
  logic       chk_err, chk_err0;
  logic [7:0] err_cnt, err_cnt0;
`endif

  nand_cell_arbiter #(.N_REQ(N), .SETTLE_CYC(SC), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .gate_a(gate_a), .gate_b(gate_b), .gate_f(gate_f), .dbg_state_o(dbg_state)
`ifdef NAND_CELL_CHECK_EN
    , .chk_err(chk_err), .err_cnt(err_cnt)
`endif
  );

  nand_cell_arbiter #(.N_REQ(N), .SETTLE_CYC(0), .ID_W(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0),
    .gate_a(gate_a0), .gate_b(gate_b0), .gate_f(gate_f0), .dbg_state_o(dbg_state0)
`ifdef NAND_CELL_CHECK_EN
    , .chk_err(chk_err0), .err_cnt(err_cnt0)
`endif
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] a;
    logic [3:0] b;
    int         exp_id;
    logic       exp_f;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first set bit at or after ptr, upward with wrap.
  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
  task automatic do_txn(input logic [3:0] r, input logic [3:0] a, input logic [3:0] b,
                        input int exp_id, input logic exp_f);
    int cyc;
    int lat;
    bus.req = r; bus.req_a = a; bus.req_b = b;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (bus.gnt == 4'b0 && cyc < 20);
    check("gnt", 32'(bus.gnt), 32'(1) << exp_id);
    check("gnt_latency", 32'(cyc), 32'd1);
    check("gate_a", 32'(gate_a), 32'(a[exp_id]));
    check("gate_b", 32'(gate_b), 32'(b[exp_id]));
    check("busy_on", 32'(bus.busy), 32'd1);
    check("no_overlap_gnt", 32'(bus.rsp_valid), 32'd0);
    bus.req = r & ~(4'b0001 << exp_id);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
      check("gnt_pulse", 32'(bus.gnt), 32'd0);
    end while (!bus.rsp_valid && lat < 20);
    check("rsp_latency", 32'(lat), 32'(SC));
    check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
    check("rsp_f", 32'(bus.rsp_f), 32'(exp_f));
    @(posedge clk); #1;
    check("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
    check("busy_off", 32'(bus.busy), 32'd0);
    model_ptr = (exp_id + 1) % N;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    32'(bus.gnt), 32'd0);
    check({tag, "_rsp_v"},  32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
    check({tag, "_rsp_f"},  32'(bus.rsp_f), 32'd0);
    check({tag, "_busy"},   32'(bus.busy), 32'd0);
    check({tag, "_gate_a"}, 32'(gate_a), 32'd0);
    check({tag, "_gate_b"}, 32'(gate_b), 32'd0);
  endtask

  initial begin
    logic [3:0] r, a, b;
    int w, cyc, lat;
    logic saw_rsp;

    stuck = 1'b0;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    bus0.req = '0; bus0.req_a = '0; bus0.req_b = '0;

    // Entries assume rr_ptr=1 (after the 0,1,2,3,0 sequence below).
    vecs[0] = '{req: 4'b0001, a: 4'b1111, b: 4'b1111, exp_id: 0, exp_f: 1'b0};
    vecs[1] = '{req: 4'b0010, a: 4'b0010, b: 4'b0000, exp_id: 1, exp_f: 1'b1};
    vecs[2] = '{req: 4'b1010, a: 4'b1000, b: 4'b1000, exp_id: 3, exp_f: 1'b0};
    vecs[3] = '{req: 4'b0010, a: 4'b0000, b: 4'b0010, exp_id: 1, exp_f: 1'b1};
    vecs[4] = '{req: 4'b0101, a: 4'b0100, b: 4'b0000, exp_id: 2, exp_f: 1'b1};
    vecs[5] = '{req: 4'b0101, a: 4'b0001, b: 4'b0001, exp_id: 0, exp_f: 1'b0};

    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_ptr = 0;

    // All four requesting, each re-requesting after its grant.
    for (int k = 0; k < 5; k++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      do_txn(4'b1111, a, b, k % N, ~(a[k % N] & b[k % N]));
    end

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].exp_id, vecs[i].exp_f);

    for (int i = 0; i < 40; i++) begin
      r = 4'($urandom_range(1, 15));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      w = model_pick(r, model_ptr);
      do_txn(r, a, b, w, ~(a[w] & b[w]));
    end

    // Abort a transaction during SETTLE with an asynchronous reset.
    bus.req = 4'b0001; bus.req_a = 4'b1111; bus.req_b = 4'b1111;
    @(posedge clk); #1;
    check("abort_gnt", 32'(bus.gnt), 32'd1);
    bus.req = 4'b0100;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("abort_no_rsp", 32'(saw_rsp), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_ptr = 0;
    do_txn(4'b0100, 4'b0100, 4'b0100, 2, 1'b0);
    // rr_ptr now 3: requests 1 and 3 go to 3 then wrap to 1.
    do_txn(4'b1010, 4'b1010, 4'b0000, 3, 1'b1);
    do_txn(4'b0010, 4'b0010, 4'b0010, 1, 1'b0);

    // SETTLE_CYC=0 instance behaves as a one-cycle settle.
    bus0.req = 4'b0010; bus0.req_a = 4'b0000; bus0.req_b = 4'b0010;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (bus0.gnt == 4'b0 && cyc < 20);
    check("s0_gnt", 32'(bus0.gnt), 32'b0010);
    bus0.req = 4'b0000;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!bus0.rsp_valid && lat < 20);
    check("s0_latency", 32'(lat), 32'd1);
    check("s0_rsp_id", 32'(bus0.rsp_id), 32'd1);
    check("s0_rsp_f", 32'(bus0.rsp_f), 32'd1);
    @(posedge clk); #1;

`ifdef NAND_CELL_CHECK_EN
    check("chk_clean", 32'(chk_err), 32'd0);
    check("cnt_clean", 32'(err_cnt), 32'd0);
    stuck = 1'b1;
    w = model_pick(4'b0001, model_ptr);
    do_txn(4'b0001, 4'b1111, 4'b1111, w, 1'b1);
    check("chk_err_set", 32'(chk_err), 32'd1);
    check("err_cnt_1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) begin
      r = 4'($urandom_range(1, 15));
      w = model_pick(r, model_ptr);
      do_txn(r, 4'b1111, 4'b1111, w, 1'b1);
    end
    check("err_cnt_sat", 32'(err_cnt), 32'd255);
    check("chk_err_sticky", 32'(chk_err), 32'd1);
    stuck = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
